// File: rtl/reg_file_mp.sv
// Multi-port register file: N combinational reads, M prioritised writes, pending scoreboard.
// Optional same-cycle write-to-read forwarding is built when REG_FILE_BYPASS_EN is defined.
module reg_file_mp #(
  parameter int ADDR_WIDTH   = 3,
  parameter int REG_WIDTH    = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2,
  parameter int ZERO_REG     = 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_RD_PORTS*REG_WIDTH-1:0]  o_rd_val,
  output logic [NUM_RD_PORTS-1:0]            o_rd_pending,
  input  logic [NUM_WR_PORTS-1:0]            i_wr_en,
  input  logic [NUM_WR_PORTS*ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [NUM_WR_PORTS*REG_WIDTH-1:0]  i_wr_val,
  input  logic                               i_claim_en,
  input  logic [ADDR_WIDTH-1:0]              i_claim_addr
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]  pending;

  function automatic logic is_hw_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Writes in ascending port order so the highest-index port lands last; a claim
  // is applied after the write clears so a same-cycle claim leaves the bit set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
      pending <= '0;
    end else begin
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (i_wr_en[w] && !is_hw_zero(i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH])) begin
          regs[i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]]    <= i_wr_val[w*REG_WIDTH +: REG_WIDTH];
          pending[i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
        end
      end
      if (i_claim_en && !is_hw_zero(i_claim_addr)) begin
        pending[i_claim_addr] <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [REG_WIDTH-1:0]  val;
    logic                  pend;

    assign ra = i_rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef REG_FILE_BYPASS_EN
    // Forward the winning in-flight write; pending then reflects only a same-cycle claim.
    always_comb begin
      val  = regs[ra];
      pend = pending[ra];
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (!i_rst && i_wr_en[w] && (i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
          val  = i_wr_val[w*REG_WIDTH +: REG_WIDTH];
          pend = i_claim_en && (i_claim_addr == ra);
        end
      end
      if (is_hw_zero(ra)) begin
        val  = '0;
        pend = 1'b0;
      end
    end
`else
    always_comb begin
      val  = regs[ra];
      pend = pending[ra];
      if (is_hw_zero(ra)) begin
        val  = '0;
        pend = 1'b0;
      end
    end
`endif

    assign o_rd_val[p*REG_WIDTH +: REG_WIDTH] = val;
    assign o_rd_pending[p]                    = pend;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized traffic vs. an array model.
module tb_reg_file_mp;
  localparam int AW = 3;
  localparam int RW = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int NREGS = 1 << AW;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic [NR*AW-1:0]   i_rd_addr;
  logic [NR*RW-1:0]   o_rd_val;
  logic [NR-1:0]      o_rd_pending;
  logic [NW-1:0]      i_wr_en;
  logic [NW*AW-1:0]   i_wr_addr;
  logic [NW*RW-1:0]   i_wr_val;
  logic               i_claim_en;
  logic [AW-1:0]      i_claim_addr;

  always #5 i_clk = ~i_clk;

  reg_file_mp #(
    .ADDR_WIDTH(AW), .REG_WIDTH(RW), .NUM_RD_PORTS(NR), .NUM_WR_PORTS(NW), .ZERO_REG(1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rd_addr(i_rd_addr), .o_rd_val(o_rd_val),
    .o_rd_pending(o_rd_pending), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_val(i_wr_val), .i_claim_en(i_claim_en), .i_claim_addr(i_claim_addr)
  );

  // Reference state: plain arrays updated once per edge from the architectural rules.
  logic [RW-1:0] m_regs [NREGS];
  logic          m_pend [NREGS];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    i_rst = 1'b0; i_wr_en = '0; i_wr_addr = '0; i_wr_val = '0;
    i_claim_en = 1'b0; i_claim_addr = '0;
  endtask

  task automatic set_wr(input int w, input int a, input logic [RW-1:0] v);
    i_wr_en[w] = 1'b1;
    i_wr_addr[w*AW +: AW] = AW'(a);
    i_wr_val[w*RW +: RW] = v;
  endtask

  task automatic set_rd(input int p, input int a);
    i_rd_addr[p*AW +: AW] = AW'(a);
  endtask

  // Expected read for the current inputs: stored state, then same-cycle forwarding if built in.
  function automatic void exp_rd(input logic [AW-1:0] a, output logic [RW-1:0] v, output logic pd);
    v = m_regs[a];
    pd = m_pend[a];
`ifdef REG_FILE_BYPASS_EN
    if (!i_rst) begin
      for (int w = 0; w < NW; w++) begin
        if (i_wr_en[w] && i_wr_addr[w*AW +: AW] == a) begin
          v = i_wr_val[w*RW +: RW];
          pd = i_claim_en && (i_claim_addr == a);
        end
      end
    end
`endif
    if (a == '0) begin
      v = '0;
      pd = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    if (i_rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 1'b0;
      end
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (i_wr_en[w] && i_wr_addr[w*AW +: AW] != '0) begin
          m_regs[i_wr_addr[w*AW +: AW]] = i_wr_val[w*RW +: RW];
          m_pend[i_wr_addr[w*AW +: AW]] = 1'b0;
        end
      end
      if (i_claim_en && i_claim_addr != '0) m_pend[i_claim_addr] = 1'b1;
    end
  endfunction

  task automatic check_model(input string tag);
    logic [RW-1:0] v;
    logic pd;
    #1;
    for (int p = 0; p < NR; p++) begin
      exp_rd(i_rd_addr[p*AW +: AW], v, pd);
      chk($sformatf("%s_val%0d", tag, p), o_rd_val[p*RW +: RW], v);
      chk($sformatf("%s_pnd%0d", tag, p), RW'(o_rd_pending[p]), RW'(pd));
    end
  endtask

  task automatic tick(input string tag, input bit do_chk);
    if (do_chk) check_model(tag);
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  // Directed read check on port p against spec-derived constants.
  task automatic rd_chk(input string tag, input int p, input int a,
                        input logic [RW-1:0] ev, input logic ep);
    set_rd(p, a);
    #1;
    chk({tag, "_val"}, o_rd_val[p*RW +: RW], ev);
    chk({tag, "_pnd"}, RW'(o_rd_pending[p]), RW'(ep));
  endtask

  initial begin
    idle();
    i_rd_addr = '0;
    i_rst = 1'b1;
    tick("rst", 1'b0);
    idle();
    for (int a = 0; a < NREGS; a++) rd_chk($sformatf("reset_a%0d", a), a % NR, a, '0, 1'b0);

    // Load regs with their index, two addresses per cycle.
    for (int a = 0; a < NREGS; a += 2) begin
      idle();
      set_wr(0, a, RW'(a));
      set_wr(1, a + 1, RW'(a + 1));
      tick("load", 1'b1);
    end
    idle();
    for (int a = 0; a < NREGS - 1; a++) begin
      set_rd(0, a);
      set_rd(1, a + 1);
      #1;
      chk($sformatf("pair%0d_p0", a), o_rd_val[0 +: RW], (a == 0) ? '0 : RW'(a));
      chk($sformatf("pair%0d_p1", a), o_rd_val[RW +: RW], RW'(a + 1));
      chk($sformatf("pair%0d_pnd", a), RW'(o_rd_pending), '0);
    end

    // Collision on address 3: port 1 must win.
    idle();
    set_wr(0, 3, 32'hAAAA);
    set_wr(1, 3, 32'h5555);
    tick("coll", 1'b1);
    idle();
    rd_chk("coll_r3", 0, 3, 32'h5555, 1'b0);

    // Claim then write clears.
    i_claim_en = 1'b1; i_claim_addr = 3'd5;
    tick("claim5", 1'b1);
    idle();
    rd_chk("claim5_r", 1, 5, 32'd5, 1'b1);
    set_wr(0, 5, 32'h12);
    tick("wr5", 1'b1);
    idle();
    rd_chk("wr5_r", 1, 5, 32'h12, 1'b0);

    // Claim and write on the same address in the same cycle: pending stays set.
    set_wr(1, 6, 32'h77);
    i_claim_en = 1'b1; i_claim_addr = 3'd6;
    tick("cw6", 1'b1);
    idle();
    rd_chk("cw6_r", 0, 6, 32'h77, 1'b1);

    // Same-cycle read of a register being written.
    set_wr(0, 2, 32'hDEAD);
`ifdef REG_FILE_BYPASS_EN
    rd_chk("byp_same", 0, 2, 32'hDEAD, 1'b0);
`else
    rd_chk("byp_same", 0, 2, 32'd2, 1'b0);
`endif
    tick("byp", 1'b1);
    idle();
    rd_chk("byp_next", 0, 2, 32'hDEAD, 1'b0);

    // Hardwired zero register ignores writes and claims.
    set_wr(1, 0, 32'hFFFF_FFFF);
    i_claim_en = 1'b1; i_claim_addr = 3'd0;
    rd_chk("zero_same", 1, 0, '0, 1'b0);
    tick("zero", 1'b1);
    idle();
    rd_chk("zero_next", 1, 0, '0, 1'b0);

    // Reset mid-operation drops the concurrent write.
    i_claim_en = 1'b1; i_claim_addr = 3'd4;
    tick("claim4", 1'b1);
    idle();
    rd_chk("claim4_r", 0, 4, 32'd4, 1'b1);
    i_rst = 1'b1;
    set_wr(0, 1, 32'h9);
    tick("rst_mid", 1'b1);
    idle();
    for (int a = 0; a < NREGS; a++) rd_chk($sformatf("rst_mid_a%0d", a), a % NR, a, '0, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      idle();
      i_rst = ($urandom_range(0, 49) == 0);
      for (int w = 0; w < NW; w++) begin
        if ($urandom_range(0, 1) == 1) set_wr(w, int'($urandom_range(0, NREGS - 1)), RW'($urandom));
      end
      i_claim_en = $urandom_range(0, 2) == 0;
      i_claim_addr = AW'($urandom_range(0, NREGS - 1));
      for (int p = 0; p < NR; p++) begin
        // Bias reads toward write targets to exercise forwarding and collisions.
        if ($urandom_range(0, 1) == 1) set_rd(p, int'(i_wr_addr[($urandom_range(0, NW - 1))*AW +: AW]));
        else set_rd(p, int'($urandom_range(0, NREGS - 1)));
      end
      tick("rand", 1'b1);
    end
    idle();
    check_model("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
